// File: rtl/gpio_bus_arbiter.sv
// gpio_bus_arbiter
//
// Bus master and two-way round-robin arbiter in front of the GPIO register
// slave. Requests from two on-chip requesters are granted one at a time and
// turned into the slave's strobe/ready handshake. Set-bits and clear-bits
// commands run as an uninterrupted read-modify-write, so the two requesters
// can never interleave partial updates to a GPIO register.
//
// Optional feature macro: GPIO_ARB_TIMEOUT_EN
//   defined   - a wait-state counter aborts an operation after TIMEOUT cycles
//               without bus_rdy_, completing it with err=1 and rdata=0.
//   undefined - wait states hold forever and err_0/err_1 are tied low.
//
// Parameters
//   DATA_W   bus data width
//   ADDR_W   GPIO register address width
//   TIMEOUT  wait-state limit in cycles (timeout feature only)
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   req_n                 operation request, held until done_n
//   op_n                  00 read, 01 write, 10 set bits, 11 clear bits
//   addr_n, wdata_n       target register, write data or bit mask
//   done_n                one-cycle completion pulse
//   err_n                 timeout flag, valid with done_n
//   rdata_n               read result (pre-modify value for set/clear)
//   busy, gnt_id          arbiter active, requester currently owned
//   bus_cs_, bus_as_      active-low strobes to the slave
//   bus_rw                1 = read, 0 = write
//   bus_addr, bus_wr_data slave address and write data
//   bus_rd_data, bus_rdy_ slave read data and active-low ready

module gpio_bus_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_0,
  input  logic              req_1,
  input  logic [1:0]        op_0,
  input  logic [1:0]        op_1,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              done_0,
  output logic              done_1,
  output logic              err_0,
  output logic              err_1,
  output logic [DATA_W-1:0] rdata_0,
  output logic [DATA_W-1:0] rdata_1,
  output logic              busy,
  output logic              gnt_id,
  output logic              bus_cs_,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_
);

  typedef enum logic [2:0] {
    IDLE,
    RD_STB,
    RD_WAIT,
    WR_STB,
    WR_WAIT,
    DONE
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLR   = 2'b11;

  state_t            state_q;
  logic              lastGnt_q;
  logic              gntId_q;
  logic              busy_q;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] mask_q;
  logic [DATA_W-1:0] preData_q;
  logic              csN_q;
  logic              asN_q;
  logic              busRw_q;
  logic [ADDR_W-1:0] busAddr_q;
  logic [DATA_W-1:0] busWrData_q;
  logic              done0_q;
  logic              done1_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic              grantSel_d;
  logic [1:0]        selOp_d;
  logic [ADDR_W-1:0] selAddr_d;
  logic [DATA_W-1:0] selWdata_d;
  logic [DATA_W-1:0] modData_d;
  logic              timeout_d;

  // Round-robin pick: on a tie the requester that did not own the bus last
  // time wins; a lone request is simply taken.
  always_comb begin
    grantSel_d = 1'b0;
    if (req_0 && req_1) begin
      grantSel_d = ~lastGnt_q;
    end else if (req_1) begin
      grantSel_d = 1'b1;
    end
    selOp_d    = grantSel_d ? op_1    : op_0;
    selAddr_d  = grantSel_d ? addr_1  : addr_0;
    selWdata_d = grantSel_d ? wdata_1 : wdata_0;
  end

  // Modify step of set/clear, applied straight to the slave's read data so
  // the write strobe can follow the read ready with no extra cycle.
  always_comb begin
    modData_d = mask_q;
    if (op_q == OP_SET) begin
      modData_d = bus_rd_data | mask_q;
    end else if (op_q == OP_CLR) begin
      modData_d = bus_rd_data & ~mask_q;
    end
  end

`ifdef GPIO_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] waitCnt_q;
  logic             err0_q;
  logic             err1_q;

  // Counts consecutive not-ready cycles in either wait state; any other
  // state, or a ready, clears it so each wait phase starts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waitCnt_q <= '0;
    end else if ((state_q == RD_WAIT || state_q == WR_WAIT) && bus_rdy_) begin
      waitCnt_q <= waitCnt_q + 1'b1;
    end else begin
      waitCnt_q <= '0;
    end
  end

  assign timeout_d = bus_rdy_ && (waitCnt_q == CNT_LAST);
  assign err_0     = err0_q;
  assign err_1     = err1_q;
`else
  // TIMEOUT only matters when the wait-state counter is built in.
  localparam int unusedTimeout = TIMEOUT;

  assign timeout_d = 1'b0;
  assign err_0     = 1'b0;
  assign err_1     = 1'b0;
`endif

  // Main sequencer. Every output is a register written on the edge that
  // enters the state it belongs to, so strobes are low exactly during the
  // *_STB states and done/rdata appear together in the DONE cycle. Requests
  // are only looked at in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      lastGnt_q   <= 1'b1;
      gntId_q     <= 1'b0;
      busy_q      <= 1'b0;
      op_q        <= OP_READ;
      mask_q      <= '0;
      preData_q   <= '0;
      csN_q       <= 1'b1;
      asN_q       <= 1'b1;
      busRw_q     <= 1'b1;
      busAddr_q   <= '0;
      busWrData_q <= '0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
`ifdef GPIO_ARB_TIMEOUT_EN
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
`endif
    end else begin
      csN_q   <= 1'b1;
      asN_q   <= 1'b1;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_0 || req_1) begin
            gntId_q   <= grantSel_d;
            busy_q    <= 1'b1;
            op_q      <= selOp_d;
            mask_q    <= selWdata_d;
            busAddr_q <= selAddr_d;
            csN_q     <= 1'b0;
            asN_q     <= 1'b0;
            if (selOp_d == OP_WRITE) begin
              busRw_q     <= 1'b0;
              busWrData_q <= selWdata_d;
              state_q     <= WR_STB;
            end else begin
              busRw_q <= 1'b1;
              state_q <= RD_STB;
            end
          end
        end
        RD_STB: begin
          state_q <= RD_WAIT;
        end
        RD_WAIT: begin
          if (!bus_rdy_) begin
            if (op_q == OP_READ) begin
              state_q <= DONE;
              done0_q <= ~gntId_q;
              done1_q <= gntId_q;
              if (gntId_q) rdata1_q <= bus_rd_data;
              else         rdata0_q <= bus_rd_data;
`ifdef GPIO_ARB_TIMEOUT_EN
              if (gntId_q) err1_q <= 1'b0;
              else         err0_q <= 1'b0;
`endif
            end else begin
              preData_q   <= bus_rd_data;
              busWrData_q <= modData_d;
              busRw_q     <= 1'b0;
              csN_q       <= 1'b0;
              asN_q       <= 1'b0;
              state_q     <= WR_STB;
            end
          end else if (timeout_d) begin
            // An RMW abandoned here never reaches the write strobe.
            state_q <= DONE;
            done0_q <= ~gntId_q;
            done1_q <= gntId_q;
            if (gntId_q) rdata1_q <= '0;
            else         rdata0_q <= '0;
`ifdef GPIO_ARB_TIMEOUT_EN
            if (gntId_q) err1_q <= 1'b1;
            else         err0_q <= 1'b1;
`endif
          end
        end
        WR_STB: begin
          state_q <= WR_WAIT;
        end
        WR_WAIT: begin
          if (!bus_rdy_ || timeout_d) begin
            state_q <= DONE;
            done0_q <= ~gntId_q;
            done1_q <= gntId_q;
            // A plain write leaves rdata alone; RMW reports the old value.
            if (timeout_d) begin
              if (gntId_q) rdata1_q <= '0;
              else         rdata0_q <= '0;
            end else if (op_q != OP_WRITE) begin
              if (gntId_q) rdata1_q <= preData_q;
              else         rdata0_q <= preData_q;
            end
`ifdef GPIO_ARB_TIMEOUT_EN
            if (gntId_q) err1_q <= timeout_d;
            else         err0_q <= timeout_d;
`endif
          end
        end
        DONE: begin
          lastGnt_q <= gntId_q;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign done_0      = done0_q;
  assign done_1      = done1_q;
  assign rdata_0     = rdata0_q;
  assign rdata_1     = rdata1_q;
  assign busy        = busy_q;
  assign gnt_id      = gntId_q;
  assign bus_cs_     = csN_q;
  assign bus_as_     = asN_q;
  assign bus_rw      = busRw_q;
  assign bus_addr    = busAddr_q;
  assign bus_wr_data = busWrData_q;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// tb_gpio_bus_arbiter
//
// Bench for gpio_bus_arbiter: a GPIO slave model with a one-cycle ready, a
// table of single operations, and hand-written sequences for contention,
// early request drop, stray ready, reset in the middle of an RMW and (with
// GPIO_ARB_TIMEOUT_EN) the wait-state timeout.

module tb_gpio_bus_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_0, req_1;
  logic [1:0]        op_0, op_1;
  logic [ADDR_W-1:0] addr_0, addr_1;
  logic [DATA_W-1:0] wdata_0, wdata_1;
  logic              done_0, done_1, err_0, err_1;
  logic [DATA_W-1:0] rdata_0, rdata_1;
  logic              busy, gnt_id;
  logic              bus_cs_, bus_as_, bus_rw;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wr_data, bus_rd_data;
  logic              bus_rdy_;

  typedef struct {
    logic        id;
    logic [1:0]  op;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] preload;
    logic [31:0] expRdata;
    logic [31:0] expWrData;
    logic        expErr;
    int          expReads;
    int          expWrites;
    int          expLat;
  } vec_t;

  typedef struct {
    logic        id;
    logic [31:0] rdata;
    logic        err;
  } sbEntry_t;

  sbEntry_t    sbQueue[$];
  vec_t        vecs[11];
  logic [31:0] heldRdata[2];
  logic [31:0] slaveRegs[4];
  int          rdCount = 0;
  int          wrCount = 0;
  logic [31:0] lastWrData = '0;
  logic [1:0]  lastWrAddr = '0;
  logic [1:0]  lastRdAddr = '0;
  bit          slaveEnable = 1'b1;
  bit          slaveStray = 1'b0;
  int          assertCount = 0;
  int          failCount = 0;

  gpio_bus_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .req_0(req_0), .req_1(req_1), .op_0(op_0), .op_1(op_1),
    .addr_0(addr_0), .addr_1(addr_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
    .done_0(done_0), .done_1(done_1), .err_0(err_0), .err_1(err_1),
    .rdata_0(rdata_0), .rdata_1(rdata_1), .busy(busy), .gnt_id(gnt_id),
    .bus_cs_(bus_cs_), .bus_as_(bus_as_), .bus_rw(bus_rw),
    .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".bus_cs_"}, bus_cs_, 1);
    checkOutput({tag, ".bus_as_"}, bus_as_, 1);
    checkOutput({tag, ".bus_rw"}, bus_rw, 1);
    checkOutput({tag, ".bus_addr"}, bus_addr, 0);
    checkOutput({tag, ".bus_wr_data"}, bus_wr_data, 0);
    checkOutput({tag, ".done"}, {done_1, done_0}, 0);
    checkOutput({tag, ".err"}, {err_1, err_0}, 0);
    checkOutput({tag, ".rdata_0"}, rdata_0, 0);
    checkOutput({tag, ".rdata_1"}, rdata_1, 0);
    checkOutput({tag, ".busy"}, busy, 0);
    checkOutput({tag, ".gnt_id"}, gnt_id, 0);
  endtask

  task automatic waitDone(output int cycles, output bit seen);
    seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (done_0 || done_1) seen = 1'b1;
    end
  endtask

  task automatic driveReq(input logic id, input logic [1:0] op,
                          input logic [1:0] addr, input logic [31:0] wdata);
    if (id) begin
      req_1 = 1'b1; op_1 = op; addr_1 = addr; wdata_1 = wdata;
    end else begin
      req_0 = 1'b1; op_0 = op; addr_0 = addr; wdata_0 = wdata;
    end
  endtask

  // One complete operation from a single requester, called just after a
  // negedge with the arbiter idle.
  task automatic applyStimulus(input vec_t v);
    int  lat;
    bit  seen;
    slaveRegs[v.addr] = v.preload;
    rdCount = 0;
    wrCount = 0;
    sbQueue.push_back('{v.id, v.expRdata, v.expErr});
    driveReq(v.id, v.op, v.addr, v.wdata);
    waitDone(lat, seen);
    req_0 = 1'b0;
    req_1 = 1'b0;
    checkOutput("doneSeen", seen, 1);
    checkOutput("latency", lat, v.expLat);
    checkOutput("busyAtDone", busy, 1);
    @(negedge clk);
    checkOutput("busyIdle", busy, 0);
    checkOutput("rdStrobes", rdCount, v.expReads);
    checkOutput("wrStrobes", wrCount, v.expWrites);
    if (v.expReads > 0) checkOutput("rdAddr", lastRdAddr, v.addr);
    if (v.expWrites > 0) begin
      checkOutput("wrAddr", lastWrAddr, v.addr);
      checkOutput("wrData", lastWrData, v.expWrData);
    end
  endtask

  // GPIO slave: samples the strobes mid-cycle and answers with ready (and
  // read data) during the following cycle.
  initial begin : slaveModel
    logic        stbLow;
    logic        prevStbLow;
    logic [31:0] pending;
    prevStbLow = 1'b0;
    pending = '0;
    bus_rdy_ = 1'b1;
    bus_rd_data = '0;
    forever begin
      @(negedge clk);
      stbLow = (bus_cs_ == 1'b0) || (bus_as_ == 1'b0);
      if (stbLow) begin
        checkOutput("strobePair", bus_as_, bus_cs_);
        checkOutput("strobeSingleCycle", prevStbLow, 0);
        if (bus_rw) begin
          rdCount++;
          lastRdAddr = bus_addr;
          pending = slaveRegs[bus_addr];
        end else begin
          wrCount++;
          lastWrData = bus_wr_data;
          lastWrAddr = bus_addr;
          slaveRegs[bus_addr] = bus_wr_data;
        end
      end
      prevStbLow = stbLow;
      @(posedge clk);
      #1;
      if (slaveStray) begin
        bus_rdy_ = 1'b0;
      end else if (stbLow && slaveEnable) begin
        bus_rdy_ = 1'b0;
        bus_rd_data = pending;
      end else begin
        bus_rdy_ = 1'b1;
      end
    end
  end

  // Every completion pops the oldest expected result and is compared
  // against it, including the grant id and the other requester's rdata.
  initial begin : scoreboardMonitor
    sbEntry_t    exp;
    logic        gotId;
    logic [31:0] gotRdata;
    logic [31:0] otherRdata;
    logic        gotErr;
    forever begin
      @(negedge clk);
      if (!reset && (done_0 || done_1)) begin
        checkOutput("singleDone", done_0 & done_1, 0);
        checkOutput("sbPending", sbQueue.size() != 0, 1);
        if (sbQueue.size() != 0) begin
          exp = sbQueue.pop_front();
          gotId = done_1;
          gotRdata = gotId ? rdata_1 : rdata_0;
          otherRdata = gotId ? rdata_0 : rdata_1;
          gotErr = gotId ? err_1 : err_0;
          checkOutput("doneId", gotId, exp.id);
          checkOutput("gntIdAtDone", gnt_id, exp.id);
          checkOutput("rdata", gotRdata, exp.rdata);
          checkOutput("err", gotErr, exp.err);
          checkOutput("otherRdataHeld", otherRdata, heldRdata[exp.id ? 0 : 1]);
          heldRdata[exp.id ? 1 : 0] = exp.rdata;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainTest
    int doneCnt;
    int lastDoneCyc;
    int lat;
    bit seen;

    // id, op, addr, wdata, preload, expRdata, expWrData, expErr, reads, writes, lat
    vecs[0]  = '{1'b0, 2'b00, 2'd2, 32'h0000_0000, 32'h0000_A5A5, 32'h0000_A5A5, 32'h0, 1'b0, 1, 0, 3};
    vecs[1]  = '{1'b0, 2'b10, 2'd1, 32'h0000_00F0, 32'h0000_0003, 32'h0000_0003, 32'h0000_00F3, 1'b0, 1, 1, 5};
    vecs[2]  = '{1'b1, 2'b11, 2'd3, 32'h0000_0001, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFE, 1'b0, 1, 1, 5};
    vecs[3]  = '{1'b1, 2'b01, 2'd0, 32'hDEAD_BEEF, 32'h0000_0000, 32'h0000_FFFF, 32'hDEAD_BEEF, 1'b0, 0, 1, 3};
    vecs[4]  = '{1'b0, 2'b00, 2'd0, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 1'b0, 1, 0, 3};
    vecs[5]  = '{1'b1, 2'b10, 2'd2, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFF_FFFF, 1'b0, 1, 1, 5};
    vecs[6]  = '{1'b0, 2'b11, 2'd1, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1, 1, 5};
    vecs[7]  = '{1'b1, 2'b00, 2'd3, 32'h0000_0000, 32'h0BAD_F00D, 32'h0BAD_F00D, 32'h0, 1'b0, 1, 0, 3};
    vecs[8]  = '{1'b1, 2'b00, 2'd2, 32'h0000_0000, 32'h600D_CAFE, 32'h600D_CAFE, 32'h0, 1'b0, 1, 0, 3};
    vecs[9]  = '{1'b0, 2'b10, 2'd1, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0000, 32'h0, 1'b1, 1, 0, 17};
    vecs[10] = '{1'b1, 2'b00, 2'd3, 32'h0000_0000, 32'h0000_0077, 32'h0000_0077, 32'h0, 1'b0, 1, 0, 3};

    heldRdata[0] = '0;
    heldRdata[1] = '0;
    for (int i = 0; i < 4; i++) slaveRegs[i] = '0;
    reset = 1'b1;
    req_0 = 1'b0; req_1 = 1'b0;
    op_0 = 2'b00; op_1 = 2'b00;
    addr_0 = '0; addr_1 = '0;
    wdata_0 = '0; wdata_1 = '0;

    repeat (3) @(negedge clk);
    checkResetValues("reset");
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] single operations");
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    $display("[TB] contention");
    slaveRegs[0] = 32'h0000_1111;
    slaveRegs[1] = 32'h0000_2222;
    sbQueue.push_back('{1'b0, 32'h0000_1111, 1'b0});
    sbQueue.push_back('{1'b1, 32'h0000_2222, 1'b0});
    sbQueue.push_back('{1'b0, 32'h0000_1111, 1'b0});
    sbQueue.push_back('{1'b1, 32'h0000_2222, 1'b0});
    driveReq(1'b0, 2'b00, 2'd0, 32'h0);
    driveReq(1'b1, 2'b00, 2'd1, 32'h0);
    doneCnt = 0;
    lastDoneCyc = 0;
    for (int c = 1; c <= 40 && doneCnt < 4; c++) begin
      @(negedge clk);
      if (done_0 || done_1) begin
        doneCnt++;
        if (doneCnt == 1) checkOutput("contentionFirstLat", c, 3);
        else              checkOutput("contentionSpacing", c - lastDoneCyc, 4);
        lastDoneCyc = c;
      end
    end
    req_0 = 1'b0;
    req_1 = 1'b0;
    checkOutput("contentionDones", doneCnt, 4);
    repeat (2) @(negedge clk);
    checkOutput("contentionIdle", busy, 0);

    $display("[TB] request dropped before done");
    slaveRegs[2] = 32'h5A5A_5A5A;
    sbQueue.push_back('{1'b1, 32'h5A5A_5A5A, 1'b0});
    driveReq(1'b1, 2'b00, 2'd2, 32'h0);
    @(negedge clk);
    req_1 = 1'b0;
    waitDone(lat, seen);
    checkOutput("dropDoneSeen", seen, 1);
    checkOutput("dropLatency", lat + 1, 3);
    repeat (3) @(negedge clk);
    checkOutput("dropNoRegrant", busy, 0);

    $display("[TB] stray ready while idle");
    slaveStray = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("strayBusy", busy, 0);
      checkOutput("strayStrobe", bus_cs_, 1);
    end
    slaveStray = 1'b0;
    @(negedge clk);

    $display("[TB] reset during RMW write strobe");
    slaveRegs[1] = 32'h0000_0030;
    rdCount = 0;
    wrCount = 0;
    driveReq(1'b0, 2'b10, 2'd1, 32'h0000_000F);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3;
    checkOutput("wrStbBeforeReset", {bus_cs_, bus_rw}, 2'b00);
    reset = 1'b1;
    req_0 = 1'b0;
    #1;
    checkResetValues("midReset");
    heldRdata[0] = '0;
    heldRdata[1] = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midResetNoWrite", wrCount, 0);
    checkOutput("midResetRegKept", slaveRegs[1], 32'h0000_0030);
    applyStimulus(vecs[8]);

`ifdef GPIO_ARB_TIMEOUT_EN
    $display("[TB] timeout on RMW");
    slaveEnable = 1'b0;
    applyStimulus(vecs[9]);
    slaveEnable = 1'b1;
    applyStimulus(vecs[10]);
`endif

    repeat (2) @(negedge clk);
    checkOutput("sbDrained", sbQueue.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/gpio_bus_arbiter.md
# gpio_bus_arbiter

Bus master and two-way arbiter for the GPIO register slave. It accepts register operations from two on-chip requesters, grants them round-robin, and sequences the GPIO slave's strobe/ready protocol (`cs_`/`as_`/`rw`/`rdy_`). Set-bits and clear-bits commands run as atomic read-modify-write sequences, so the requesters never interleave partial updates to `gpio_out`, `io_out` or `io_dir`. It sits between the requesters and the GPIO slave port.

## Interface
- `DATA_W`, 32, bus data width.
- `ADDR_W`, 2, GPIO register address width.
- `TIMEOUT`, 15, wait-state limit in cycles (used only with the timeout feature).

- `clk` in 1 — system clock.
- `reset` in 1 — asynchronous, active-high reset.
- `req_0`, `req_1` in 1 — operation request; held high until the matching `done_n`.
- `op_0`, `op_1` in 2 — command: 00 read, 01 write, 10 set bits (OR mask), 11 clear bits (AND NOT mask).
- `addr_0`, `addr_1` in ADDR_W — target register.
- `wdata_0`, `wdata_1` in DATA_W — write data or bit mask.
- `done_0`, `done_1` out 1 — one-cycle completion pulse.
- `err_0`, `err_1` out 1 — valid with `done_n`; high on timeout.
- `rdata_0`, `rdata_1` out DATA_W — read result (for RMW: the pre-modify value); held until that requester's next completion.
- `busy` out 1 — high in every state except IDLE.
- `gnt_id` out 1 — requester currently owned; meaningful while `busy`.
- `bus_cs_`, `bus_as_` out 1 — active-low strobes to the slave.
- `bus_rw` out 1 — 1 = read, 0 = write.
- `bus_addr` out ADDR_W — slave address.
- `bus_wr_data` out DATA_W — slave write data.
- `bus_rd_data` in DATA_W — slave read data.
- `bus_rdy_` in 1 — active-low slave ready.

## Operation
- **FSM states:** IDLE, RD_STB, RD_WAIT, WR_STB, WR_WAIT, DONE. Outputs are registered; strobes are low only in the *_STB states.
- **Grant (IDLE):**
  - If any `req` is high, grant it and latch its op, addr and wdata.
  - If both are high, grant the requester not granted last. The last-grant pointer resets to 1, so requester 0 wins the first tie.
- **Next state from IDLE:**
  - read, set, clear → RD_STB.
  - write → WR_STB.
- **Read path:**
  - RD_STB: strobes low for exactly one cycle, `bus_rw`=1 → RD_WAIT.
  - RD_WAIT: strobes high; when `bus_rdy_`=0, capture `bus_rd_data`.
  - read → DONE; set/clear → WR_STB.
- **Modify:**
  - set: `bus_wr_data` = captured | mask.
  - clear: `bus_wr_data` = captured & ~mask.
  - write: `bus_wr_data` = wdata.
  - Full DATA_W width, no carries.
- **Write path:**
  - WR_STB: one-cycle strobe, `bus_rw`=0 → WR_WAIT.
  - WR_WAIT: leave on `bus_rdy_`=0 → DONE.
- **DONE:**
  - Pulse `done_n` for the granted requester; update its `rdata_n` (read/RMW) and `err_n`.
  - Update the last-grant pointer, then go to IDLE.
  - `req` is not sampled in DONE, so a requester that drops `req` on `done` is never re-granted spuriously.
- A stray `bus_rdy_` low outside the WAIT states is ignored.

## Timing
- Latency from the IDLE edge that samples `req` to the `done` cycle:
  - read and write: 3 cycles.
  - set/clear: 5 cycles.
  - These figures assume the slave's 1-cycle ready.
- Back-to-back: IDLE takes 1 cycle between operations, so minimum spacing between two completions is 4 cycles (read/write) or 6 cycles (RMW).
- **Reset values:** state IDLE; `bus_cs_`=`bus_as_`=1; `bus_rw`=1; `bus_addr`=0; `bus_wr_data`=0; `done_*`=0; `err_*`=0; `rdata_*`=0; `busy`=0; `gnt_id`=0.
- **Reset mid-operation:** strobes deassert immediately (asynchronous). The pending operation is discarded with no `done`, and a half-done RMW never writes.
- A requester whose `req` drops before `done` still has its operation completed; the `done` pulse is issued regardless.

## Configuration
- `GPIO_ARB_TIMEOUT_EN` defined:
  - A counter runs in RD_WAIT and WR_WAIT.
  - If `bus_rdy_` stays high for TIMEOUT cycles, go to DONE with `err`=1 and `rdata`=0.
  - An RMW aborted in RD_WAIT performs no write.
- `GPIO_ARB_TIMEOUT_EN` undefined:
  - No counter; the WAIT states hold indefinitely.
  - `err_0`/`err_1` are tied to 0.

## Test plan
- **Read:** `req_0`, op 00, addr 2; slave returns 0x0000_A5A5 → exactly one RD strobe cycle; `done_0` 3 cycles after grant; `rdata_0`=0x0000_A5A5; `err_0`=0.
- **Set bits:** op 10, addr 1, mask 0x0000_00F0; slave reads 0x0000_0003 → one read strobe, then one write strobe with `bus_wr_data`=0x0000_00F3; `done` at cycle 5.
- **Clear bits:** op 11, addr 3, mask 0x0000_0001; read 0x0000_FFFF → write 0x0000_FFFE.
- **Contention:** `req_0` and `req_1` rise on the same cycle and stay high → grant order 0, 1, 0, 1. The bus shows no overlapping strobes, and `gnt_id` matches each `done`.
- **Timeout (macro on, TIMEOUT=15):** slave never asserts `bus_rdy_` on an RMW → `done` with `err`=1 after 15 wait cycles; no write strobe issued; next request is served normally.
- **Reset mid-RMW:** assert `reset` in WR_STB → strobes go high within the same cycle; all outputs at reset values; no `done`.
